// File: rtl/fpadd_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fpadd_rr_scheduler
//
// Shares one combinational single-precision FP adder among NREQ requesters.
// A round-robin arbiter picks one pending request, the operands are registered
// and held on the adder for EXEC_CYCLES cycles (multicycle path), and the
// captured sum/overflow is returned to the granted requester over a
// valid/ready response. One operation is in flight at a time.
//
// Parameters
//   NREQ         number of requesters (2..8)
//   EXEC_CYCLES  cycles the operands are held on the adder before capture (1..15)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   req_valid_i  per-requester operation request
//   req_a_i      operand A, requester i at [32*i+31:32*i]
//   req_b_i      operand B, same packing
//   req_ready_o  one-hot accept pulse (op taken when req_valid_i[i] & req_ready_o[i])
//   rsp_valid_o  one-hot result valid to the granted requester
//   rsp_ready_i  per-requester result acceptance
//   rsp_sum_o    result shared by all requesters, qualified by rsp_valid_o
//   rsp_ovf_o    adder overflow flag belonging to rsp_sum_o
//   add_a_o      operand A to the shared adder
//   add_b_o      operand B to the shared adder
//   add_sum_i    adder result (combinational from add_a_o/add_b_o)
//   add_ovf_i    adder overflow flag
//   busy_o       high in any state other than IDLE
//
// Optional feature, macro FPADD_SCHED_PERF_EN:
//   op_count_o   [15:0] completed response handshakes, wraps at 0xFFFF
//   ovf_count_o  [7:0]  completed responses with overflow, saturates at 0xFF
// -----------------------------------------------------------------------------
module fpadd_rr_scheduler #(
   parameter int NREQ        = 4,
   parameter int EXEC_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [32*NREQ-1:0]   req_a_i,
   input  logic [32*NREQ-1:0]   req_b_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic [NREQ-1:0]      rsp_valid_o,
   input  logic [NREQ-1:0]      rsp_ready_i,
   output logic [31:0]          rsp_sum_o,
   output logic                 rsp_ovf_o,
   output logic [31:0]          add_a_o,
   output logic [31:0]          add_b_o,
   input  logic [31:0]          add_sum_i,
   input  logic                 add_ovf_i,
   output logic                 busy_o
`ifdef FPADD_SCHED_PERF_EN
   ,
   output logic [15:0]          op_count_o,
   output logic [7:0]           ovf_count_o
`endif
);

   localparam int         PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;     // last served requester
   logic [PTR_W-1:0]  gnt_q, gnt_d;     // requester owning the op in flight
   logic [3:0]        cnt_q, cnt_d;     // remaining EXEC cycles minus one
   logic [31:0]       add_a_q, add_a_d;
   logic [31:0]       add_b_q, add_b_d;
   logic [31:0]       rsp_sum_q, rsp_sum_d;
   logic              rsp_ovf_q, rsp_ovf_d;

   logic              arb_found;
   logic [PTR_W-1:0]  arb_idx;
   logic [31:0]       sel_a, sel_b;
   logic              rsp_done;

   // --------------------------------------------------------------------------
   // Round-robin search: first valid requester starting just after ptr_q,
   // so the last served requester has the lowest priority.
   // --------------------------------------------------------------------------
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] idx_w;
      arb_found = 1'b0;
      arb_idx   = '0;
      idx       = 0;
      idx_w     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         idx_w = PTR_W'(idx);
         if (!arb_found && req_valid_i[idx_w]) begin
            arb_found = 1'b1;
            arb_idx   = idx_w;
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_idx == PTR_W'(i)) begin
            sel_a = req_a_i[32*i +: 32];
            sel_b = req_b_i[32*i +: 32];
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state and outputs.
   // --------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      cnt_d       = cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_ovf_d   = rsp_ovf_q;
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_done    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               req_ready_o[arb_idx] = 1'b1;
               add_a_d              = sel_a;
               add_b_d              = sel_b;
               gnt_d                = arb_idx;
               cnt_d                = CNT_LOAD;
               state_d              = S_EXEC;
            end
         end

         S_EXEC: begin
            // Operands stay put on the adder; capture once the count expires.
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_sum_d = add_sum_i;
               rsp_ovf_d = add_ovf_i;
               state_d   = S_RESP;
            end
         end

         S_RESP: begin
            rsp_valid_o[gnt_q] = 1'b1;
            // Only the owner's rsp_ready counts; others are ignored.
            if (rsp_ready_i[gnt_q]) begin
               ptr_d    = gnt_q;
               rsp_done = 1'b1;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The grant path is combinational from req_valid_i; keep the accept
      // pulse quiet while reset is held so no requester sees a phantom accept.
      if (rst) begin
         req_ready_o = '0;
      end
   end

   // --------------------------------------------------------------------------
   // State registers.
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= PTR_W'(NREQ - 1);   // requester 0 gets first priority
         gnt_q     <= '0;
         cnt_q     <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         rsp_sum_q <= '0;
         rsp_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         cnt_q     <= cnt_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         rsp_sum_q <= rsp_sum_d;
         rsp_ovf_q <= rsp_ovf_d;
      end
   end

   assign add_a_o   = add_a_q;
   assign add_b_o   = add_b_q;
   assign rsp_sum_o = rsp_sum_q;
   assign rsp_ovf_o = rsp_ovf_q;
   assign busy_o    = (state_q != S_IDLE);

`ifdef FPADD_SCHED_PERF_EN
   // --------------------------------------------------------------------------
   // Performance counters, stepped on each completed response handshake.
   // --------------------------------------------------------------------------
   logic [15:0] op_cnt_q, op_cnt_d;
   logic [7:0]  ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      op_cnt_d  = op_cnt_q;
      ovf_cnt_d = ovf_cnt_q;
      if (rsp_done) begin
         op_cnt_d = op_cnt_q + 16'd1;              // wraps naturally
         if (rsp_ovf_q && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_d = ovf_cnt_q + 8'd1;          // saturating
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt_q  <= '0;
         ovf_cnt_q <= '0;
      end else begin
         op_cnt_q  <= op_cnt_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign op_count_o  = op_cnt_q;
   assign ovf_count_o = ovf_cnt_q;
`endif

endmodule
